// File: rtl/dut_seq_ctrl_if.sv
// Handshake/data bundle between the sequencer and its driver, plus the locked-DUT side.
// master: the controlling environment; slave: dut_seq_ctrl.
interface dut_seq_ctrl_if;
    logic        start;
    logic        abort;
    logic [35:0] in_vec;
    logic [9:0]  key_vec;
    logic [6:0]  exp_out;
    logic [7:0]  run_count;
    logic [45:0] dut_inputs;
    logic [6:0]  dut_outputs;
    logic        trigger;
    logic        busy;
    logic        done;
    logic        err;
    logic        aborted;
    logic [6:0]  result;
    logic [7:0]  mismatch_cnt;

    modport master (
        output start, abort, in_vec, key_vec, exp_out, run_count, dut_outputs,
        input  dut_inputs, trigger, busy, done, err, aborted, result, mismatch_cnt
    );

    modport slave (
        input  start, abort, in_vec, key_vec, exp_out, run_count, dut_outputs,
        output dut_inputs, trigger, busy, done, err, aborted, result, mismatch_cnt
    );
endinterface

// File: rtl/dut_seq_ctrl.sv
// Iterative stimulus sequencer for a locked DUT: trigger lead, apply, capture, gap,
// with mismatch counting against an expected response.
module dut_seq_ctrl #(
    parameter int unsigned TRIG_LEAD     = 2,
    parameter int unsigned SETTLE_CYCLES = 4,
    parameter int unsigned GAP_CYCLES    = 3
) (
    input logic           clk,
    input logic           rst_n,
    dut_seq_ctrl_if.slave bus
);
    typedef enum logic [2:0] {StIdle, StPre, StApply, StCapture, StGap, StDone} state_e;

    localparam logic [7:0] PreLast   = 8'(TRIG_LEAD - 1);
    localparam logic [7:0] ApplyLast = 8'(SETTLE_CYCLES - 1);
    localparam logic [7:0] GapLast   = 8'(GAP_CYCLES - 1);

    state_e      state_q, state_d;
    logic [7:0]  phase_q, phase_d;
    logic [7:0]  iter_q, iter_d;
    logic [35:0] in_q, in_d;
    logic [9:0]  key_q, key_d;
    logic [6:0]  exp_q, exp_d;
    logic [6:0]  result_q, result_d;
    logic [7:0]  mm_q, mm_d;
    logic        err_q, err_d;
    logic        aborted_q, aborted_d;

    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q + 8'd1;
        iter_d    = iter_q;
        in_d      = in_q;
        key_d     = key_q;
        exp_d     = exp_q;
        result_d  = result_q;
        mm_d      = mm_q;
        err_d     = err_q;
        aborted_d = aborted_q;
        unique case (state_q)
            StIdle: begin
                phase_d = '0;
                if (bus.start) begin
                    in_d      = bus.in_vec;
                    key_d     = bus.key_vec;
                    exp_d     = bus.exp_out;
                    iter_d    = bus.run_count;
                    err_d     = (bus.run_count == 8'd0);
                    aborted_d = 1'b0;
                    mm_d      = '0;
                    state_d   = (bus.run_count == 8'd0) ? StDone : StPre;
                end
            end
            StPre: begin
                if (phase_q == PreLast) begin
                    state_d = StApply;
                    phase_d = '0;
                end
            end
            StApply: begin
                if (phase_q == ApplyLast) begin
                    state_d = StCapture;
                    phase_d = '0;
                end
            end
            StCapture: begin
                result_d = bus.dut_outputs;
                if (bus.dut_outputs != exp_q && mm_q != 8'hFF) begin
                    mm_d = mm_q + 8'd1;
                end
                iter_d  = iter_q - 8'd1;
                state_d = StGap;
                phase_d = '0;
            end
            StGap: begin
                if (phase_q == GapLast) begin
                    phase_d = '0;
                    state_d = (iter_q != 8'd0) ? StPre : StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
                phase_d = '0;
            end
            default: begin
                state_d = StIdle;
                phase_d = '0;
            end
        endcase
        // Abort overrides everything, including a capture in this same cycle.
        if (state_q != StIdle && bus.abort) begin
            state_d   = StIdle;
            phase_d   = '0;
            iter_d    = iter_q;
            result_d  = result_q;
            mm_d      = mm_q;
            aborted_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            phase_q   <= '0;
            iter_q    <= '0;
            in_q      <= '0;
            key_q     <= '0;
            exp_q     <= '0;
            result_q  <= '0;
            mm_q      <= '0;
            err_q     <= 1'b0;
            aborted_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            iter_q    <= iter_d;
            in_q      <= in_d;
            key_q     <= key_d;
            exp_q     <= exp_d;
            result_q  <= result_d;
            mm_q      <= mm_d;
            err_q     <= err_d;
            aborted_q <= aborted_d;
        end
    end

    // Outputs decode from state only; key stays on the bus from PRE through DONE.
    always_comb begin
        bus.dut_inputs = '0;
        bus.trigger    = 1'b0;
        unique case (state_q)
            StPre: begin
                bus.dut_inputs = {key_q, 36'b0};
                bus.trigger    = 1'b1;
            end
            StApply: begin
                bus.dut_inputs = {key_q, in_q};
                bus.trigger    = 1'b1;
            end
            StCapture: bus.dut_inputs = {key_q, in_q};
            StGap:     bus.dut_inputs = {key_q, 36'b0};
            StDone:    bus.dut_inputs = {key_q, 36'b0};
            default:   bus.dut_inputs = '0;
        endcase
    end

    assign bus.busy         = (state_q != StIdle);
    assign bus.done         = (state_q == StDone);
    assign bus.err          = err_q;
    assign bus.aborted      = aborted_q;
    assign bus.result       = result_q;
    assign bus.mismatch_cnt = mm_q;
endmodule
